// File: rtl/paddle_pos_ctrl.sv
// Paddle position controller: synchronised, debounced left/right buttons step a clamped 3-bit position.
// Build option: define PADDLE_AUTOREPEAT_EN for hold-to-repeat; otherwise one step per debounced press.
module paddle_pos_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_RATE     = 24'd2500000,
    parameter logic [2:0]  POS_MAX         = 3'd5,
    parameter logic [2:0]  POS_RESET       = 3'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       enable,
    input  logic       center,
    output logic [2:0] pos,
    output logic       moved,
    output logic       at_edge
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
`ifdef PADDLE_AUTOREPEAT_EN
    localparam logic [1:0] REPEAT = 2'd2;
`endif

    if (DEBOUNCE_CYCLES == 16'd0 || REPEAT_DELAY == 24'd0 || REPEAT_RATE == 24'd0) begin : g_bad_params
        $error("paddle_pos_ctrl: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;
    logic [1:0][15:0] cnt_q;
    logic [1:0][15:0] cnt_d;

    logic       req_left;
    logic       req_right;
    logic       req_any;
    logic       same_req;
    logic       step;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       dir_q;
    logic       dir_d;
    logic [2:0] pos_q;
    logic [2:0] pos_d;
    logic       moved_q;
    logic       moved_d;
`ifdef PADDLE_AUTOREPEAT_EN
    logic [23:0] timer_q;
    logic [23:0] timer_d;
`endif

    assign btn_raw = {btn_right, btn_left};

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if ({1'b0, cnt_q[i]} + 17'd1 == {1'b0, DEBOUNCE_CYCLES}) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign req_left  = deb_q[0] & ~deb_q[1];
    assign req_right = deb_q[1] & ~deb_q[0];
    assign req_any   = req_left | req_right;
    assign same_req  = req_any & (req_right == dir_q);

    // The timer holds "cycles remaining minus one", so a step fires when it reads zero.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        step    = 1'b0;
`ifdef PADDLE_AUTOREPEAT_EN
        timer_d = timer_q;
`endif
        if (enable && !center) begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        step    = 1'b1;
                        dir_d   = req_right;
                        state_d = HOLD;
`ifdef PADDLE_AUTOREPEAT_EN
                        timer_d = REPEAT_DELAY - 24'd1;
`endif
                    end
                end
                HOLD: begin
                    if (!same_req) begin
                        state_d = IDLE;
                    end
`ifdef PADDLE_AUTOREPEAT_EN
                    else if (timer_q == 24'd0) begin
                        step    = 1'b1;
                        timer_d = REPEAT_RATE - 24'd1;
                        state_d = REPEAT;
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
`endif
                end
`ifdef PADDLE_AUTOREPEAT_EN
                REPEAT: begin
                    if (!same_req) begin
                        state_d = IDLE;
                    end else if (timer_q == 24'd0) begin
                        step    = 1'b1;
                        timer_d = REPEAT_RATE - 24'd1;
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    // center wins over a step; a clamped step leaves pos unchanged and so raises no moved.
    always_comb begin
        pos_d = pos_q;
        if (center) begin
            pos_d = POS_RESET;
        end else if (step) begin
            if (dir_d && pos_q < POS_MAX) begin
                pos_d = pos_q + 3'd1;
            end else if (!dir_d && pos_q != 3'd0) begin
                pos_d = pos_q - 3'd1;
            end
        end
        moved_d = (pos_d != pos_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            dir_q   <= 1'b0;
            pos_q   <= POS_RESET;
            moved_q <= 1'b0;
`ifdef PADDLE_AUTOREPEAT_EN
            timer_q <= '0;
`endif
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            moved_q <= moved_d;
`ifdef PADDLE_AUTOREPEAT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign pos     = pos_q;
    assign moved   = moved_q;
    assign at_edge = (pos_q == 3'd0) || (pos_q == POS_MAX);

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Bench for paddle_pos_ctrl: directed vector table, hand-written corner sequences and random stimulus vs a reference model.
module tb_paddle_pos_ctrl;

    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RR   = 3;
    localparam int PMAX = 5;
    localparam int PRST = 2;
`ifdef PADDLE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_left;
    logic       btn_right;
    logic       enable;
    logic       center;
    logic [2:0] pos;
    logic       moved;
    logic       at_edge;

    paddle_pos_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd10),
        .REPEAT_RATE    (24'd3),
        .POS_MAX        (3'd5),
        .POS_RESET      (3'd2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .enable   (enable),
        .center   (center),
        .pos      (pos),
        .moved    (moved),
        .at_edge  (at_edge)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: raw history, sync-sample window per button, and a press-age view of the stepping rules.
    bit rh [2][2];
    bit sw [2][D];
    int since [2];
    bit m_deb [2];
    bit m_active;
    int m_dir;
    int m_age;
    int m_pos;
    bit m_moved;

    typedef struct {
        bit l;
        bit r;
        bit en;
        bit ctr;
        int n;
        int exp_pos;
        bit exp_moved;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            rh[b][0] = 1'b0;
            rh[b][1] = 1'b0;
            for (int k = 0; k < D; k++) sw[b][k] = 1'b0;
            since[b] = D;
            m_deb[b] = 1'b0;
        end
        m_active = 1'b0;
        m_dir    = 0;
        m_age    = 0;
        m_pos    = PRST;
        m_moved  = 1'b0;
    endtask

    task automatic model_step();
        bit inr [2];
        bit nd [2];
        bit s;
        bit all_diff;
        bit stp;
        int req;
        int np;
        inr[0] = btn_left;
        inr[1] = btn_right;
        req = (m_deb[0] && !m_deb[1]) ? -1 : ((m_deb[1] && !m_deb[0]) ? 1 : 0);
        for (int b = 0; b < 2; b++) begin
            s = rh[b][1];
            rh[b][1] = rh[b][0];
            rh[b][0] = inr[b];
            for (int k = D - 1; k > 0; k--) sw[b][k] = sw[b][k-1];
            sw[b][0] = s;
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) if (sw[b][k] == m_deb[b]) all_diff = 1'b0;
            if (since[b] < 1000) since[b]++;
            nd[b] = m_deb[b];
            if (all_diff && since[b] >= D) begin
                nd[b] = !m_deb[b];
                since[b] = 0;
            end
        end
        stp = 1'b0;
        if (!enable || center) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (req != 0) begin
                stp      = 1'b1;
                m_active = 1'b1;
                m_dir    = req;
                m_age    = 0;
            end
        end else if (req != m_dir) begin
            m_active = 1'b0;
        end else begin
            m_age++;
            if (AR && (m_age == RD || (m_age > RD && (m_age - RD) % RR == 0))) stp = 1'b1;
        end
        np = m_pos;
        if (center) begin
            np = PRST;
        end else if (stp) begin
            np = m_pos + m_dir;
            if (np < 0) np = 0;
            if (np > PMAX) np = PMAX;
        end
        m_moved = (np != m_pos);
        m_pos   = np;
        m_deb   = nd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_pos", int'(pos), m_pos);
        check("model_moved", int'(moved), int'(m_moved));
        check("model_at_edge", int'(at_edge), int'(m_pos == 0 || m_pos == PMAX));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int saved_pos;
        int seg_len;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 6, 2, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 3, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 3, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 12, 3, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 3, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 2, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8, 1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 1, 1'b0};

        rst_n     = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        enable    = 1'b1;
        center    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pos", int'(pos), PRST);
        check("reset_moved", int'(moved), 0);
        check("reset_at_edge", int'(at_edge), 0);
        rst_n = 1'b1;
        model_reset();
        ticks(3);
        check("post_reset_pos", int'(pos), PRST);

        // Directed vector table
        for (int v = 0; v < 10; v++) begin
            btn_left  = vecs[v].l;
            btn_right = vecs[v].r;
            enable    = vecs[v].en;
            center    = vecs[v].ctr;
            ticks(vecs[v].n);
            check($sformatf("vec%0d_pos", v), int'(pos), vecs[v].exp_pos);
            check($sformatf("vec%0d_moved", v), int'(moved), int'(vecs[v].exp_moved));
        end
        btn_left = 1'b0;
        btn_right = 1'b0;
        enable = 1'b1;
        center = 1'b0;

        // Re-centre from 1, then a long right hold
        center = 1'b1;
        tick();
        check("center_pos", int'(pos), PRST);
        check("center_moved", int'(moved), 1);
        center = 1'b0;
        ticks(5);
        btn_right = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
`ifdef PADDLE_AUTOREPEAT_EN
            if (k == 6) check("hold_pre_step", int'(pos), 2);
            if (k == 7) begin
                check("hold_step1_pos", int'(pos), 3);
                check("hold_step1_moved", int'(moved), 1);
            end
            if (k == 8) check("hold_step1_pulse_end", int'(moved), 0);
            if (k == 16) check("hold_pre_step2", int'(pos), 3);
            if (k == 17) check("hold_step2_pos", int'(pos), 4);
            if (k == 19) check("hold_pre_step3", int'(pos), 4);
            if (k == 20) begin
                check("hold_step3_pos", int'(pos), 5);
                check("hold_step3_moved", int'(moved), 1);
                check("hold_step3_at_edge", int'(at_edge), 1);
            end
            if (k > 20) begin
                check("hold_sat_pos", int'(pos), 5);
                check("hold_sat_moved", int'(moved), 0);
            end
`else
            if (k == 6) check("hold_pre_step", int'(pos), 2);
            if (k == 7) begin
                check("hold_single_step_pos", int'(pos), 3);
                check("hold_single_step_moved", int'(moved), 1);
            end
            if (k > 7) begin
                check("hold_no_repeat_pos", int'(pos), 3);
                check("hold_no_repeat_moved", int'(moved), 0);
            end
`endif
        end
        btn_right = 1'b0;
        ticks(15);

        // Bounce shorter than the debounce window
        saved_pos = m_pos;
        for (int k = 0; k < 20; k++) begin
            btn_left = ((k / 2) % 2 == 0);
            tick();
            check("bounce_moved", int'(moved), 0);
        end
        btn_left = 1'b0;
        ticks(10);
        check("bounce_pos", int'(pos), saved_pos);

        // Both held, then left released
        center = 1'b1;
        tick();
        check("center2_pos", int'(pos), PRST);
        center = 1'b0;
        ticks(3);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("both_pos", int'(pos), PRST);
            check("both_moved", int'(moved), 0);
        end
        btn_left = 1'b0;
        ticks(6);
        check("both_release_pre", int'(pos), 2);
        tick();
        check("both_release_step_pos", int'(pos), 3);
        check("both_release_step_moved", int'(moved), 1);
        btn_right = 1'b0;
        ticks(15);

        // Walk down to 0, then collide center with a left step
        for (int g = 0; g < 8 && m_pos != 0; g++) begin
            btn_left = 1'b1;
            ticks(6);
            btn_left = 1'b0;
            ticks(10);
        end
        check("walk_to_zero", int'(pos), 0);
        btn_left = 1'b1;
        ticks(6);
        check("collide_pre", int'(pos), 0);
        center = 1'b1;
        tick();
        check("collide_pos", int'(pos), PRST);
        check("collide_moved", int'(moved), 1);
        center = 1'b0;
        enable = 1'b0;
        tick();
        check("collide_after_pos", int'(pos), PRST);
        check("collide_after_moved", int'(moved), 0);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("frozen_pos", int'(pos), PRST);
            check("frozen_moved", int'(moved), 0);
        end
        btn_right = 1'b0;
        ticks(10);
        enable = 1'b1;
        ticks(3);

        // Reset asserted mid-hold; the held button counts as a new press afterwards
        btn_right = 1'b1;
        ticks(12);
        check("prereset_pos", int'(pos), 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_pos", int'(pos), PRST);
        check("midreset_moved", int'(moved), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        ticks(6);
        check("rearm_pre", int'(pos), 2);
        tick();
        check("rearm_step_pos", int'(pos), 3);
        check("rearm_step_moved", int'(moved), 1);
        btn_right = 1'b0;
        ticks(15);

        // Random stimulus against the model
        for (int seg = 0; seg < 150; seg++) begin
            btn_left  = ($urandom_range(0, 2) == 0);
            btn_right = ($urandom_range(0, 1) == 1);
            enable    = ($urandom_range(0, 9) != 0);
            seg_len   = $urandom_range(1, 40);
            for (int k = 0; k < seg_len; k++) begin
                center = ($urandom_range(0, 63) == 0);
                tick();
            end
            center = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
